// File: rtl/forth_regfile_v2.sv
// Forth core register bank: 2 registered read ports, general + PC write, PSP/RSP push/pop with sticky bounds errors.
// Optional macro FORTH_REGFILE_BYPASS_EN forwards same-edge updates into the read ports.
module forth_regfile_v2 #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int PSP_MIN = 48,
   parameter int PSP_MAX = 55,
   parameter int RSP_MIN = 56,
   parameter int RSP_MAX = 63
) (
   input  logic              c_CLOCK,
   input  logic              c_RESETn,
   input  logic [1:0]        i_SSRSet,
   input  logic [ADDR_W-1:0] i_RADDRA,
   output logic [DATA_W-1:0] o_RDATAA,
   input  logic [ADDR_W-1:0] i_RADDRB,
   output logic [DATA_W-1:0] o_RDATAB,
   input  logic              f_WRITE,
   input  logic [ADDR_W-1:0] i_WADDR,
   input  logic [DATA_W-1:0] i_DATA,
   input  logic              f_PCWRITE,
   input  logic [DATA_W-1:0] i_PCDATA,
   input  logic [1:0]        i_PSPOP,
   input  logic [1:0]        i_RSPOP,
   input  logic              f_FLAGCLR,
   output logic              o_SSR,
   output logic [DATA_W-1:0] o_PC,
   output logic [DATA_W-1:0] o_PSP,
   output logic [DATA_W-1:0] o_RSP,
   output logic [DATA_W-1:0] o_OfR,
   output logic [3:0]        o_STKERR
);

   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] L_PSP_MIN = DATA_W'(PSP_MIN);
   localparam logic [DATA_W-1:0] L_PSP_MAX = DATA_W'(PSP_MAX);
   localparam logic [DATA_W-1:0] L_RSP_MIN = DATA_W'(RSP_MIN);
   localparam logic [DATA_W-1:0] L_RSP_MAX = DATA_W'(RSP_MAX);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] w_reg_next [NREGS];
   logic              w_wr_hit [NREGS];
   logic [DATA_W-1:0] r_rdata_a;
   logic [DATA_W-1:0] r_rdata_b;
   logic              r_ssr;
   logic [3:0]        r_stkerr;
   logic [DATA_W-1:0] w_psp_move;
   logic [DATA_W-1:0] w_rsp_move;
   logic [3:0]        w_err_new;

   // Stack moves; a general write to the same pointer suppresses the op and its flag.
   always_comb begin
      w_psp_move = r_regs[1];
      w_rsp_move = r_regs[2];
      w_err_new  = 4'b0000;
      if (!w_wr_hit[1]) begin
         case (i_PSPOP)
            2'b01: if (r_regs[1] == L_PSP_MAX) w_err_new[0] = 1'b1;
                   else w_psp_move = r_regs[1] + DATA_W'(1);
            2'b10: if (r_regs[1] == L_PSP_MIN) w_err_new[1] = 1'b1;
                   else w_psp_move = r_regs[1] - DATA_W'(1);
            default: ;
         endcase
      end
      if (!w_wr_hit[2]) begin
         case (i_RSPOP)
            2'b01: if (r_regs[2] == L_RSP_MAX) w_err_new[2] = 1'b1;
                   else w_rsp_move = r_regs[2] + DATA_W'(1);
            2'b10: if (r_regs[2] == L_RSP_MIN) w_err_new[3] = 1'b1;
                   else w_rsp_move = r_regs[2] - DATA_W'(1);
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         assign w_wr_hit[gi] = f_WRITE && (i_WADDR == ADDR_W'(gi));
         if (gi == 0) begin : g_pc
            assign w_reg_next[gi] = w_wr_hit[gi] ? i_DATA :
                                    (f_PCWRITE ? i_PCDATA : r_regs[gi]);
         end else if (gi == 1) begin : g_psp
            assign w_reg_next[gi] = w_wr_hit[gi] ? i_DATA : w_psp_move;
         end else if (gi == 2) begin : g_rsp
            assign w_reg_next[gi] = w_wr_hit[gi] ? i_DATA : w_rsp_move;
         end else begin : g_gen
            assign w_reg_next[gi] = w_wr_hit[gi] ? i_DATA : r_regs[gi];
         end
      end
   endgenerate

   always_ff @(posedge c_CLOCK or negedge c_RESETn) begin
      if (!c_RESETn) begin
         for (int k = 0; k < NREGS; k++) begin
            r_regs[k] <= (k == 1) ? L_PSP_MIN : ((k == 2) ? L_RSP_MIN : '0);
         end
         r_rdata_a <= '0;
         r_rdata_b <= '0;
         r_ssr     <= 1'b0;
         r_stkerr  <= 4'b0000;
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            r_regs[k] <= w_reg_next[k];
         end
`ifdef FORTH_REGFILE_BYPASS_EN
         r_rdata_a <= w_reg_next[i_RADDRA];
         r_rdata_b <= w_reg_next[i_RADDRB];
`else
         r_rdata_a <= r_regs[i_RADDRA];
         r_rdata_b <= r_regs[i_RADDRB];
`endif
         case (i_SSRSet)
            2'd0:    r_ssr <= 1'b0;
            2'd1:    r_ssr <= 1'b1;
            default: r_ssr <= r_ssr;
         endcase
         // New errors are OR'd after the clear so they survive a same-cycle clear.
         r_stkerr <= (f_FLAGCLR ? 4'b0000 : r_stkerr) | w_err_new;
      end
   end

   assign o_RDATAA = r_rdata_a;
   assign o_RDATAB = r_rdata_b;
   assign o_SSR    = r_ssr;
   assign o_STKERR = r_stkerr;
   assign o_PC     = r_regs[0];
   assign o_PSP    = r_regs[1];
   assign o_RSP    = r_regs[2];
   assign o_OfR    = r_regs[3];

endmodule

// File: tb/tb_forth_regfile_v2.sv
// Directed self-checking bench for forth_regfile_v2 (expectations follow FORTH_REGFILE_BYPASS_EN if defined).
module tb_forth_regfile_v2;

   logic        c_CLOCK = 1'b0;
   logic        c_RESETn;
   logic [1:0]  i_SSRSet;
   logic [3:0]  i_RADDRA, i_RADDRB, i_WADDR;
   logic [15:0] o_RDATAA, o_RDATAB, i_DATA, i_PCDATA;
   logic        f_WRITE, f_PCWRITE, f_FLAGCLR;
   logic [1:0]  i_PSPOP, i_RSPOP;
   logic        o_SSR;
   logic [15:0] o_PC, o_PSP, o_RSP, o_OfR;
   logic [3:0]  o_STKERR;

   int checks = 0;
   int failures = 0;

   forth_regfile_v2 dut (
      .c_CLOCK(c_CLOCK), .c_RESETn(c_RESETn), .i_SSRSet(i_SSRSet),
      .i_RADDRA(i_RADDRA), .o_RDATAA(o_RDATAA), .i_RADDRB(i_RADDRB), .o_RDATAB(o_RDATAB),
      .f_WRITE(f_WRITE), .i_WADDR(i_WADDR), .i_DATA(i_DATA),
      .f_PCWRITE(f_PCWRITE), .i_PCDATA(i_PCDATA),
      .i_PSPOP(i_PSPOP), .i_RSPOP(i_RSPOP), .f_FLAGCLR(f_FLAGCLR),
      .o_SSR(o_SSR), .o_PC(o_PC), .o_PSP(o_PSP), .o_RSP(o_RSP), .o_OfR(o_OfR),
      .o_STKERR(o_STKERR)
   );

   always #5 c_CLOCK = ~c_CLOCK;

   task automatic idle_inputs();
      i_SSRSet = 2'd2; i_RADDRA = 4'd0; i_RADDRB = 4'd0;
      f_WRITE = 1'b0; i_WADDR = 4'd0; i_DATA = 16'h0;
      f_PCWRITE = 1'b0; i_PCDATA = 16'h0;
      i_PSPOP = 2'b00; i_RSPOP = 2'b00; f_FLAGCLR = 1'b0;
   endtask

   task automatic tick();
      @(posedge c_CLOCK);
      #1;
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else
         $display("ok   %s = %h", name, act);
   endtask

   task automatic test_reset();
      idle_inputs();
      c_RESETn = 1'b0;
      #12;
      chk16("rst_pc", o_PC, 16'h0);
      chk16("rst_psp", o_PSP, 16'd48);
      chk16("rst_rsp", o_RSP, 16'd56);
      chk16("rst_ofr", o_OfR, 16'h0);
      chk16("rst_ssr", {15'b0, o_SSR}, 16'h0);
      chk16("rst_err", {12'b0, o_STKERR}, 16'h0);
      chk16("rst_rda", o_RDATAA, 16'h0);
      chk16("rst_rdb", o_RDATAB, 16'h0);
      @(posedge c_CLOCK); #1;
      c_RESETn = 1'b1;
      tick();
   endtask

   task automatic test_psp_push_overflow();
      logic [15:0] exp;
      for (int i = 1; i <= 8; i++) begin
         i_PSPOP = 2'b01;
         tick();
         exp = (i < 8) ? 16'(48 + i) : 16'd55;
         chk16($sformatf("psp_push%0d", i), o_PSP, exp);
      end
      idle_inputs();
      chk16("psp_ovf_err", {12'b0, o_STKERR}, 16'h0001);
      f_FLAGCLR = 1'b1; tick(); idle_inputs();
      chk16("psp_ovf_clr", {12'b0, o_STKERR}, 16'h0000);
   endtask

   task automatic test_rsp_pop_flagclr();
      i_RSPOP = 2'b10; f_FLAGCLR = 1'b1; tick(); idle_inputs();
      chk16("rsp_unf_hold", o_RSP, 16'd56);
      chk16("rsp_unf_err", {12'b0, o_STKERR}, 16'h0008);
      f_FLAGCLR = 1'b1; tick(); idle_inputs();
      chk16("rsp_unf_clr", {12'b0, o_STKERR}, 16'h0000);
   endtask

   task automatic test_pc_priority();
      f_WRITE = 1'b1; i_WADDR = 4'd0; i_DATA = 16'h1234;
      f_PCWRITE = 1'b1; i_PCDATA = 16'h0042; tick(); idle_inputs();
      chk16("pc_gen_wins", o_PC, 16'h1234);
      f_PCWRITE = 1'b1; i_PCDATA = 16'h0042; tick(); idle_inputs();
      chk16("pc_write", o_PC, 16'h0042);
   endtask

   task automatic test_pointer_write();
      f_WRITE = 1'b1; i_WADDR = 4'd1; i_DATA = 16'h0030; i_PSPOP = 2'b01; tick(); idle_inputs();
      chk16("psp_wr_wins", o_PSP, 16'h0030);
      chk16("psp_wr_noerr", {12'b0, o_STKERR}, 16'h0000);
      i_PSPOP = 2'b01; tick(); idle_inputs();
      chk16("psp_oor_push", o_PSP, 16'h0031);
      i_PSPOP = 2'b10; tick(); idle_inputs();
      chk16("psp_oor_pop", o_PSP, 16'h0030);
      f_WRITE = 1'b1; i_WADDR = 4'd1; i_DATA = 16'd48; tick(); idle_inputs();
      i_PSPOP = 2'b10; tick(); idle_inputs();
      chk16("psp_unf_hold", o_PSP, 16'd48);
      chk16("psp_unf_err", {12'b0, o_STKERR}, 16'h0002);
      f_WRITE = 1'b1; i_WADDR = 4'd2; i_DATA = 16'd63; tick(); idle_inputs();
      i_RSPOP = 2'b01; tick(); idle_inputs();
      chk16("rsp_ovf_hold", o_RSP, 16'd63);
      chk16("rsp_ovf_err", {12'b0, o_STKERR}, 16'h0006);
      f_FLAGCLR = 1'b1; tick(); idle_inputs();
   endtask

   task automatic test_simultaneous();
      f_PCWRITE = 1'b1; i_PCDATA = 16'hABCD; i_PSPOP = 2'b01; i_RSPOP = 2'b10;
      f_WRITE = 1'b1; i_WADDR = 4'd3; i_DATA = 16'h5A5A; tick(); idle_inputs();
      chk16("sim_pc", o_PC, 16'hABCD);
      chk16("sim_psp", o_PSP, 16'd49);
      chk16("sim_rsp", o_RSP, 16'd62);
      chk16("sim_ofr", o_OfR, 16'h5A5A);
      chk16("sim_err", {12'b0, o_STKERR}, 16'h0000);
   endtask

   task automatic test_read_ports();
      logic [15:0] exp_a;
      f_WRITE = 1'b1; i_WADDR = 4'd5; i_DATA = 16'hBEEF; i_RADDRA = 4'd5; tick(); idle_inputs();
`ifdef FORTH_REGFILE_BYPASS_EN
      exp_a = 16'hBEEF;
`else
      exp_a = 16'h0000;
`endif
      chk16("rd_same_edge_a", o_RDATAA, exp_a);
      i_RADDRB = 4'd5; i_RADDRA = 4'd3; tick(); idle_inputs();
      chk16("rd_next_b", o_RDATAB, 16'hBEEF);
      chk16("rd_a_reg3", o_RDATAA, 16'h5A5A);
      i_RADDRA = 4'd1; i_RADDRB = 4'd1; i_PSPOP = 2'b01; tick(); idle_inputs();
`ifdef FORTH_REGFILE_BYPASS_EN
      exp_a = 16'd50;
`else
      exp_a = 16'd49;
`endif
      chk16("rd_psp_a", o_RDATAA, exp_a);
      chk16("rd_psp_b", o_RDATAB, exp_a);
   endtask

   task automatic test_ssr();
      i_SSRSet = 2'd1; tick(); chk16("ssr_set", {15'b0, o_SSR}, 16'h1);
      i_SSRSet = 2'd2; tick(); chk16("ssr_hold2", {15'b0, o_SSR}, 16'h1);
      i_SSRSet = 2'd3; tick(); chk16("ssr_hold3", {15'b0, o_SSR}, 16'h1);
      i_SSRSet = 2'd0; tick(); chk16("ssr_clr", {15'b0, o_SSR}, 16'h0);
      idle_inputs();
   endtask

   task automatic test_reset_midrun();
      i_SSRSet = 2'd1; i_RSPOP = 2'b10; i_RADDRA = 4'd5; i_RADDRB = 4'd3; tick();
      i_RSPOP = 2'b00; i_PSPOP = 2'b00;
      f_WRITE = 1'b1; i_WADDR = 4'd2; i_DATA = 16'd56; tick();
      f_WRITE = 1'b0; i_RSPOP = 2'b10; tick(); idle_inputs();
      chk16("pre_rst_err", {12'b0, o_STKERR}, 16'h0008);
      #2;
      c_RESETn = 1'b0;
      #1;
      chk16("mid_pc", o_PC, 16'h0);
      chk16("mid_psp", o_PSP, 16'd48);
      chk16("mid_rsp", o_RSP, 16'd56);
      chk16("mid_ssr", {15'b0, o_SSR}, 16'h0);
      chk16("mid_rda", o_RDATAA, 16'h0);
      chk16("mid_rdb", o_RDATAB, 16'h0);
      chk16("mid_err", {12'b0, o_STKERR}, 16'h0);
      @(posedge c_CLOCK); #1;
      c_RESETn = 1'b1;
      tick();
      chk16("post_rst_psp", o_PSP, 16'd48);
   endtask

   initial begin
      test_reset();
      test_psp_push_overflow();
      test_rsp_pop_flagclr();
      test_pc_priority();
      test_pointer_write();
      test_simultaneous();
      test_read_ports();
      test_ssr();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
